// File: rtl/mult_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the sequential multiplier controller:
//   - FSM state encodings (ST_IDLE, ST_RUN, ST_DONE, ST_NEG) and the enum
//     built on them
//   - ALU opcode constants shared with the 32-bit ALU
// -----------------------------------------------------------------------------
package mult_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;
   localparam logic [1:0] ST_NEG  = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE = ST_IDLE,
      S_RUN  = ST_RUN,
      S_DONE = ST_DONE,
      S_NEG  = ST_NEG
   } mult_state_e;

   localparam logic [2:0] ALU_OP_ADD  = 3'b000;
   localparam logic [2:0] ALU_OP_XOR  = 3'b001;
   localparam logic [2:0] ALU_OP_SUB  = 3'b010;
   localparam logic [2:0] ALU_OP_MULT = 3'b011;
   localparam logic [2:0] ALU_OP_SLT  = 3'b100;
   localparam logic [2:0] ALU_OP_NOR  = 3'b101;
   localparam logic [2:0] ALU_OP_AND  = 3'b110;
   localparam logic [2:0] ALU_OP_OR   = 3'b111;

endpackage

// File: rtl/mult_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// mult_seq_ctrl_if
// Bundles the request/result handshake and the ALU drive/return signals of
// the multiplier controller.
//   slave  : the controller (receives start/operands and ALU result)
//   master : the surrounding datapath (issues requests, hosts the ALU)
// -----------------------------------------------------------------------------
interface mult_seq_ctrl_if #(
   parameter int WIDTH = 32
);

   logic             start;
   logic [WIDTH-1:0] multiplicand;
   logic [WIDTH-1:0] multiplier;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] product_hi;
   logic [WIDTH-1:0] product_lo;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [2:0]       alu_op;
   logic [WIDTH-1:0] alu_res;
   logic             alu_cout;

   modport slave (
      input  start, multiplicand, multiplier, alu_res, alu_cout,
      output busy, done, product_hi, product_lo, alu_a, alu_b, alu_op
   );

   modport master (
      output start, multiplicand, multiplier, alu_res, alu_cout,
      input  busy, done, product_hi, product_lo, alu_a, alu_b, alu_op
   );

endinterface

// File: rtl/mult_iter_cnt.sv
// -----------------------------------------------------------------------------
// mult_iter_cnt
// Clearable CNT_W-bit up-counter tracking multiplier iterations.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr_i      : synchronous clear (wins over en_i)
//   en_i       : count enable
//   term_o     : high while the count equals WIDTH-1 (last iteration)
// -----------------------------------------------------------------------------
module mult_iter_cnt #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic en_i,
   output logic term_o
);

   localparam logic [CNT_W-1:0] TERM_VAL = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: clear, increment or hold.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = {CNT_W{1'b0}};
      end else if (en_i) begin
         cnt_d = cnt_q + ONE;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= {CNT_W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign term_o = (cnt_q == TERM_VAL);

endmodule

// File: rtl/mult_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mult_seq_ctrl
// Shift-and-add multiplier controller for MULT. Each RUN cycle it drives the
// external ALU with the running high half and the captured multiplicand and
// folds the ALU sum/carry back into a right-shifting 2*WIDTH product.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : mult_seq_ctrl_if.slave (start/operands in, busy/done/product
//                out, alu_a/alu_b/alu_op out, alu_res/alu_cout in)
// Build option:
//   MULT_SIGNED_EN : two's-complement operands; magnitudes are multiplied and
//                    a NEG cycle fixes the sign (latency WIDTH+2 instead of
//                    WIDTH+1).
// -----------------------------------------------------------------------------
module mult_seq_ctrl
   import mult_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic           clk,
   input  logic           rst_n,
   mult_seq_ctrl_if.slave bus
);

   mult_state_e      state_q, state_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] p_hi_q, p_hi_d;
   logic [WIDTH-1:0] p_lo_q, p_lo_d;
   logic [WIDTH-1:0] prod_hi_q, prod_hi_d;
   logic [WIDTH-1:0] prod_lo_q, prod_lo_d;
   logic [WIDTH-1:0] alu_a_q, alu_a_d;
   logic [WIDTH-1:0] alu_b_q, alu_b_d;
   logic [2:0]       alu_op_q, alu_op_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [WIDTH:0]   step_s;
   logic [WIDTH-1:0] iter_hi_s, iter_lo_s;
   logic [WIDTH-1:0] ld_mcand_s, ld_mplier_s;
   logic             cnt_clr_s, cnt_en_s, cnt_term_s;

`ifdef MULT_SIGNED_EN
   logic               sign_q, sign_d, ld_sign_s;
   logic [2*WIDTH-1:0] full_s, neg_s;

   // Magnitude of a two's-complement value; the most-negative value maps to
   // 2^(WIDTH-1), which is still representable as unsigned.
   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
      if (v[WIDTH-1]) begin
         mag = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
      end else begin
         mag = v;
      end
   endfunction

   assign ld_mcand_s  = mag(bus.multiplicand);
   assign ld_mplier_s = mag(bus.multiplier);
   assign ld_sign_s   = bus.multiplicand[WIDTH-1] ^ bus.multiplier[WIDTH-1];
   assign full_s      = {p_hi_q, p_lo_q};
   assign neg_s       = {(2*WIDTH){1'b0}} - full_s;
`else
   assign ld_mcand_s  = bus.multiplicand;
   assign ld_mplier_s = bus.multiplier;
`endif

   mult_iter_cnt #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr_i  (cnt_clr_s),
      .en_i   (cnt_en_s),
      .term_o (cnt_term_s)
   );

   // One shift-and-add step: add the multiplicand only when the current
   // multiplier bit is set, then shift the (2W+1)-bit value right so the
   // ALU carry lands in the top bit of the high half.
   always_comb begin
      step_s = {1'b0, p_hi_q};
      if (p_lo_q[0]) begin
         step_s = {bus.alu_cout, bus.alu_res};
      end else begin
         step_s = {1'b0, p_hi_q};
      end
      iter_hi_s = step_s[WIDTH:1];
      iter_lo_s = {step_s[0], p_lo_q[WIDTH-1:1]};
   end

   // FSM next state, datapath next values and the next registered outputs.
   always_comb begin
      state_d   = state_q;
      mcand_d   = mcand_q;
      p_hi_d    = p_hi_q;
      p_lo_d    = p_lo_q;
      prod_hi_d = prod_hi_q;
      prod_lo_d = prod_lo_q;
      cnt_clr_s = 1'b0;
      cnt_en_s  = 1'b0;
`ifdef MULT_SIGNED_EN
      sign_d    = sign_q;
`endif
      case (state_q)
         // DONE accepts a new request exactly like IDLE (back-to-back).
         S_IDLE, S_DONE: begin
            if (bus.start) begin
               state_d   = S_RUN;
               mcand_d   = ld_mcand_s;
               p_hi_d    = {WIDTH{1'b0}};
               p_lo_d    = ld_mplier_s;
               cnt_clr_s = 1'b1;
`ifdef MULT_SIGNED_EN
               sign_d    = ld_sign_s;
`endif
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            cnt_en_s = 1'b1;
            p_hi_d   = iter_hi_s;
            p_lo_d   = iter_lo_s;
            if (cnt_term_s) begin
`ifdef MULT_SIGNED_EN
               state_d   = S_NEG;
`else
               state_d   = S_DONE;
               prod_hi_d = iter_hi_s;
               prod_lo_d = iter_lo_s;
`endif
            end else begin
               state_d = S_RUN;
            end
         end
`ifdef MULT_SIGNED_EN
         S_NEG: begin
            state_d = S_DONE;
            if (sign_q) begin
               {prod_hi_d, prod_lo_d} = neg_s;
            end else begin
               {prod_hi_d, prod_lo_d} = full_s;
            end
         end
`endif
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Outputs are registered, so they are derived from the next state.
      if (state_d == S_RUN) begin
         alu_a_d  = p_hi_d;
         alu_b_d  = mcand_d;
         alu_op_d = ALU_OP_MULT;
      end else begin
         alu_a_d  = {WIDTH{1'b0}};
         alu_b_d  = {WIDTH{1'b0}};
         alu_op_d = ALU_OP_ADD;
      end
      busy_d = (state_d == S_RUN) || (state_d == S_NEG);
      done_d = (state_d == S_DONE);
   end

   // State, datapath and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         mcand_q   <= {WIDTH{1'b0}};
         p_hi_q    <= {WIDTH{1'b0}};
         p_lo_q    <= {WIDTH{1'b0}};
         prod_hi_q <= {WIDTH{1'b0}};
         prod_lo_q <= {WIDTH{1'b0}};
         alu_a_q   <= {WIDTH{1'b0}};
         alu_b_q   <= {WIDTH{1'b0}};
         alu_op_q  <= ALU_OP_ADD;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
`ifdef MULT_SIGNED_EN
         sign_q    <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         mcand_q   <= mcand_d;
         p_hi_q    <= p_hi_d;
         p_lo_q    <= p_lo_d;
         prod_hi_q <= prod_hi_d;
         prod_lo_q <= prod_lo_d;
         alu_a_q   <= alu_a_d;
         alu_b_q   <= alu_b_d;
         alu_op_q  <= alu_op_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
`ifdef MULT_SIGNED_EN
         sign_q    <= sign_d;
`endif
      end
   end

   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.product_hi = prod_hi_q;
   assign bus.product_lo = prod_lo_q;
   assign bus.alu_a      = alu_a_q;
   assign bus.alu_b      = alu_b_q;
   assign bus.alu_op     = alu_op_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mult_seq_ctrl
// Directed bench for mult_seq_ctrl with a behavioural ALU and a transaction
// level reference (operation timer + arithmetic product). Honours
// MULT_SIGNED_EN when the same define is given to the whole build.
// -----------------------------------------------------------------------------
module tb_mult_seq_ctrl;

   localparam int W = 32;
`ifdef MULT_SIGNED_EN
   localparam int SIGNED_B = 1;
`else
   localparam int SIGNED_B = 0;
`endif
   localparam int LAT      = W + 1 + SIGNED_B;   // start-accept edge to done cycle
   localparam int BUSY_CYC = W + SIGNED_B;       // busy cycles per operation

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   int vectors     = 0;
   int miscompares = 0;

   mult_seq_ctrl_if #(.WIDTH(W)) bus ();

   mult_seq_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Behavioural ALU: MULT routes through the adder.
   assign {bus.alu_cout, bus.alu_res} = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] ref_product(input logic [31:0] a, input logic [31:0] b);
      longint sa, sb;
      if (SIGNED_B != 0) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = longint'({32'd0, a});
         sb = longint'({32'd0, b});
      end
      ref_product = 64'(sa * sb);
   endfunction

   function automatic logic [31:0] ref_mag(input logic [31:0] a);
      if (SIGNED_B != 0 && a[31]) ref_mag = 32'd0 - a;
      else                        ref_mag = a;
   endfunction

   // Reference: a countdown of remaining busy cycles plus the arithmetic result.
   int          left_m  = 0;
   logic        done_m  = 1'b0;
   logic [63:0] prod_m  = 64'd0;
   logic [63:0] pend_m  = 64'd0;
   logic [31:0] mcand_m = 32'd0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         left_m <= 0;
         done_m <= 1'b0;
         prod_m <= 64'd0;
      end else if (left_m != 0) begin
         left_m <= left_m - 1;
         if (left_m == 1) begin
            done_m <= 1'b1;
            prod_m <= pend_m;
         end else begin
            done_m <= 1'b0;
         end
      end else begin
         done_m <= 1'b0;
         if (bus.start) begin
            left_m  <= BUSY_CYC;
            pend_m  <= ref_product(bus.multiplicand, bus.multiplier);
            mcand_m <= ref_mag(bus.multiplicand);
         end
      end
   end

   // Per-cycle comparison against the reference, away from the active edge.
   always @(negedge clk) begin
      check("busy", 64'(bus.busy), 64'(left_m != 0));
      check("done", 64'(bus.done), 64'(done_m));
      check("product_hi", 64'(bus.product_hi), 64'(prod_m[63:32]));
      check("product_lo", 64'(bus.product_lo), 64'(prod_m[31:0]));
      if (left_m > SIGNED_B) begin
         check("alu_op_run", 64'(bus.alu_op), 64'(3'b011));
         check("alu_b_run", 64'(bus.alu_b), 64'(mcand_m));
      end else begin
         check("alu_op_idle", 64'(bus.alu_op), 64'(3'b000));
         check("alu_a_idle", 64'(bus.alu_a), 64'd0);
         check("alu_b_idle", 64'(bus.alu_b), 64'd0);
      end
   end

   task automatic issue(input logic [31:0] a, input logic [31:0] b);
      @(posedge clk); #1;
      bus.start        = 1'b1;
      bus.multiplicand = a;
      bus.multiplier   = b;
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   // Cycles from the accepting edge until done is seen, and busy cycles in between.
   task automatic wait_done(output int cyc, output int bc);
      bit seen = 1'b0;
      cyc = 0;
      bc  = 0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         cyc++;
         if (bus.busy) bc++;
         if (bus.done) seen = 1'b1;
      end
      if (!seen) check("done_timeout", 64'd0, 64'd1);
   endtask

   task automatic check_result(input string name, input logic [31:0] hi, input logic [31:0] lo);
      check({name, "_hi"}, 64'(bus.product_hi), 64'(hi));
      check({name, "_lo"}, 64'(bus.product_lo), 64'(lo));
   endtask

   initial begin
      int cyc, bc, ndone;
      bus.start        = 1'b0;
      bus.multiplicand = 32'd0;
      bus.multiplier   = 32'd0;
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;
      @(negedge clk);
      check("reset_busy", 64'(bus.busy), 64'd0);
      check("reset_done", 64'(bus.done), 64'd0);
      check("reset_prod", {bus.product_hi, bus.product_lo}, 64'd0);
      check("reset_alu_op", 64'(bus.alu_op), 64'd0);

      // 3 x 5: latency and busy window
      issue(32'd3, 32'd5);
      wait_done(cyc, bc);
      check("lat_3x5", 64'(cyc), 64'(LAT));
      check("busy_cycles_3x5", 64'(bc), 64'(BUSY_CYC));
      check_result("3x5", 32'h0000_0000, 32'h0000_000F);

      // all-ones operands exercise carry propagation
      issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done(cyc, bc);
      if (SIGNED_B != 0) check_result("ff_x_ff", 32'h0000_0000, 32'h0000_0001);
      else               check_result("ff_x_ff", 32'hFFFF_FFFE, 32'h0000_0001);

      // second start while busy is ignored
      issue(32'd7, 32'd9);
      repeat (8) @(negedge clk);
      issue(32'd2, 32'd2);
      wait_done(cyc, bc);
      check_result("7x9", 32'h0000_0000, 32'h0000_003F);

      // asynchronous reset mid-operation
      issue(32'h1234, 32'h5678);
      repeat (14) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_busy", 64'(bus.busy), 64'd0);
      check("arst_done", 64'(bus.done), 64'd0);
      check("arst_prod", {bus.product_hi, bus.product_lo}, 64'd0);
      check("arst_alu", {29'd0, bus.alu_op, bus.alu_a}, 64'd0);
      check("arst_alu_b", 64'(bus.alu_b), 64'd0);
      @(posedge clk); #3 rst_n = 1'b1;
      ndone = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.done) ndone++;
      end
      check("no_done_after_rst", 64'(ndone), 64'd0);

      issue(32'd6, 32'd7);
      wait_done(cyc, bc);
      check_result("6x7", 32'h0000_0000, 32'h0000_002A);

      // back-to-back: start held during the done cycle
      bus.start        = 1'b1;
      bus.multiplicand = 32'h0001_0000;
      bus.multiplier   = 32'h0001_0000;
      @(posedge clk); #1;
      bus.start = 1'b0;
      wait_done(cyc, bc);
      check("lat_b2b", 64'(cyc), 64'(LAT));
      check_result("b2b", 32'h0000_0001, 32'h0000_0000);

      // negative / most-negative operands
      issue(32'hFFFF_FFFD, 32'd5);
      wait_done(cyc, bc);
      check("lat_m3x5", 64'(cyc), 64'(LAT));
      if (SIGNED_B != 0) check_result("m3x5", 32'hFFFF_FFFF, 32'hFFFF_FFF1);
      else               check_result("m3x5", 32'h0000_0004, 32'hFFFF_FFF1);

      issue(32'h8000_0000, 32'd2);
      wait_done(cyc, bc);
      if (SIGNED_B != 0) check_result("minx2", 32'hFFFF_FFFF, 32'h0000_0000);
      else               check_result("minx2", 32'h0000_0001, 32'h0000_0000);

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mult_seq_ctrl.md
Name: mult_seq_ctrl

Overview:
- Multi-cycle shift-and-add multiplier controller for the miniMIPS MULT instruction.
- Sits directly upstream of the 32-bit ALU. Each cycle it drives the ALU's operand and op inputs with alu_op=3'b011 (MULT, which routes through the sum path). It consumes the ALU sum and carry-out to build the 2W-bit product.
- Results go to the HI/LO writeback path.

Parameters:
- WIDTH, 32, operand width. Product is 2*WIDTH wide. Must be ≥2.
- CNT_W, 6, iteration counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse. Sampled only when the block is not busy.
- multiplicand  input  WIDTH  operand A. Captured on start acceptance.
- multiplier  input  WIDTH  operand B. Captured on start acceptance.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse: product_hi/product_lo are valid.
- product_hi  output  WIDTH  upper half of the result.
- product_lo  output  WIDTH  lower half of the result.
- alu_a  output  WIDTH  ALU operand a (running partial product, high half).
- alu_b  output  WIDTH  ALU operand b (registered multiplicand).
- alu_op  output  3  ALU opcode.
- alu_res  input  WIDTH  ALU result (combinational from alu_a/alu_b/alu_op).
- alu_cout  input  1  ALU carry-out of the MSB slice.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: busy=0, done=0, product_hi=0, product_lo=0, alu_a=0, alu_b=0, alu_op=3'b000. FSM goes to IDLE and the counter is cleared.
- FSM states: IDLE, RUN, DONE (plus NEG, only with the optional feature).
- IDLE:
  - start=1: load mcand_r=multiplicand, P_hi=0, P_lo=multiplier, cnt=0, then go to RUN.
  - start=0: stay in IDLE.
- RUN (busy=1): one iteration per cycle.
  - ALU drive: alu_a=P_hi, alu_b=mcand_r, alu_op=3'b011.
  - If P_lo[0]=1: {c,sum} = {alu_cout, alu_res}. Otherwise {c,sum} = {0, P_hi}.
  - Update: {P_hi,P_lo} <= {c, sum, P_lo[WIDTH-1:1]}, i.e. a logical right shift of the (2W+1)-bit value.
  - cnt increments each cycle. On the iteration where cnt=WIDTH-1, go to DONE.
- DONE: done=1 and busy=0 for exactly one cycle. product_hi/product_lo are loaded on entry to DONE, i.e. valid in the same cycle done is high.
  - Next state is IDLE, or RUN if start=1 in this cycle (back-to-back acceptance).
- Outputs outside RUN: alu_a=0, alu_b=0, alu_op=3'b000.
- Latency: start accepted at edge E0, iterations at E1..E_WIDTH, done high in the cycle after E_WIDTH. That is WIDTH+1 cycles from start to done.
- Latency is fixed regardless of operand values; zero operands still take WIDTH iterations.
- start while busy=1 is ignored. Operands are not recaptured.
- product_hi/product_lo hold their last result until the next completion. They are not disturbed by a new start.
- Reset mid-operation aborts immediately and returns all outputs to their reset values. No done is produced.
- Carry out of the high half is never lost: it is shifted into P_hi[WIDTH-1].

Optional Feature:
- MULT_SIGNED_EN defined: operands are treated as two's complement.
  - At acceptance, the absolute values are loaded; the sign is recorded as sign_r = A[MSB] ^ B[MSB].
  - After RUN, a NEG state (busy=1, one cycle) negates the 2W-bit product if sign_r=1.
  - Latency becomes WIDTH+2. Special case: the most-negative operand's magnitude is interpreted as unsigned 2^(WIDTH-1).
- MULT_SIGNED_EN undefined: unsigned only, no NEG state, latency WIDTH+1.

Decomposition:
- Shared package mult_pkg contains:
  - FSM state encoding localparams ST_IDLE, ST_RUN, ST_DONE, ST_NEG.
  - ALU opcode constants shared with the ALU team: ALU_OP_ADD=3'b000, ALU_OP_XOR=3'b001, ALU_OP_SUB=3'b010, ALU_OP_MULT=3'b011, ALU_OP_SLT=3'b100, ALU_OP_NOR=3'b101, ALU_OP_AND=3'b110, ALU_OP_OR=3'b111.
- One sub-module is natural: mult_iter_cnt, a clearable CNT_W-bit up-counter with terminal flag (cnt==WIDTH-1).

Test Plan:
- 3 × 5 (WIDTH=32, behavioural ALU model) → done exactly 33 cycles after start; hi=0x00000000, lo=0x0000000F; busy high cycles 1–32.
- 0xFFFFFFFF × 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. Carry propagation is checked.
- Start 7×9, then pulse start with 2×2 at cycle 10 → second request ignored; result hi=0, lo=0x3F.
- Assert rst_n=0 at cycle 15 of 0x1234×0x5678 → all outputs 0 asynchronously; no done; next start 6×7 gives lo=0x2A.
- start held high in the DONE cycle with new operands 0x10000×0x10000 → accepted back-to-back; next result hi=0x00000001, lo=0.
- With MULT_SIGNED_EN: (-3)×5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1, latency 34 cycles. 0x80000000×2 → hi=0xFFFFFFFF, lo=0x00000000.
